// File: rtl/fir_pkg.sv
// fir_pkg: opcodes, controller states and fixed register indices for the FIR sequencer
package fir_pkg;
  typedef enum logic [2:0] {OP_NOP, OP_COPY, OP_LOAD1, OP_LOAD2, OP_ADD, OP_SUB, OP_MUL} op_t;
  typedef enum logic [2:0] {S_IDLE, S_LOADC, S_SHIFT, S_STORE, S_ZERO, S_MUL, S_ACC, S_EIDLE} state_t;
  localparam logic [3:0] RESULT_REG = 4'd0;
  localparam logic [3:0] SAMPLE_REG = 4'd1;
  localparam logic [3:0] TEMP_REG = 4'd15;
endpackage

// File: rtl/fir_ctrl_counter.sv
// fir_ctrl_counter: loadable up/down tap counter with terminal-value flag
module fir_ctrl_counter #(
  parameter logic UP = 1'b1,
  parameter logic [2:0] TERM = 3'd0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  input  logic [2:0] init,
  output logic [2:0] cnt,
  output logic term
);
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= init;
    else if (en) cnt <= UP ? cnt + 3'd1 : cnt - 3'd1;
  end
  assign term = cnt == TERM;
endmodule

// File: rtl/fir_controller.sv
// fir_controller: Moore sequencer issuing FIR micro-ops to the register-file/ALU datapath.
// OVERFLOW_ABORT_EN: abort to EIDLE with sticky err on datapath overflow during MUL/ACC.
module fir_controller
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = 4
) (
  input  logic clk,
  input  logic n_reset,
  input  logic dr,
  input  logic lc,
  input  logic overflow,
  output logic [2:0] op,
  output logic [3:0] src1,
  output logic [3:0] src2,
  output logic [3:0] dest,
  output logic modwait,
  output logic cnt_up,
  output logic err
);
  localparam logic [2:0] LAST = 3'(NUM_TAPS - 1);
  localparam logic [3:0] COEF0 = 4'(NUM_TAPS + 1);
  state_t state, next;
  op_t o;
  logic [2:0] i, k, cidx;
  logic i_term, k_term, accept, abort;
  assign accept = (state == S_IDLE || state == S_EIDLE) && dr;
  fir_ctrl_counter #(.UP(1'b0), .TERM(3'd1)) u_i (
    .clk(clk), .rst(n_reset), .load(accept), .en(state == S_SHIFT),
    .init(LAST), .cnt(i), .term(i_term)
  );
  fir_ctrl_counter #(.UP(1'b1), .TERM(LAST)) u_k (
    .clk(clk), .rst(n_reset), .load(state == S_ZERO), .en(state == S_ACC),
    .init(3'd0), .cnt(k), .term(k_term)
  );
`ifdef OVERFLOW_ABORT_EN
  logic err_r;
  assign abort = overflow && (state == S_MUL || state == S_ACC);
  always_ff @(posedge clk) begin
    if (n_reset) err_r <= 1'b0;
    else if (abort) err_r <= 1'b1;
    else if (accept) err_r <= 1'b0;
  end
  assign err = err_r;
`else
  logic unused_overflow;
  assign unused_overflow = overflow;
  assign abort = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (n_reset) begin
      state <= S_IDLE;
      cidx <= '0;
    end else begin
      state <= next;
      if (state == S_LOADC) cidx <= cidx == LAST ? 3'd0 : cidx + 3'd1;
    end
  end
  always_comb begin
    next = state;
    case (state)
      S_IDLE, S_EIDLE: next = dr ? (NUM_TAPS == 1 ? S_STORE : S_SHIFT) : lc ? S_LOADC : state;
      S_LOADC: next = S_IDLE;
      S_SHIFT: next = i_term ? S_STORE : S_SHIFT;
      S_STORE: next = S_ZERO;
      S_ZERO: next = S_MUL;
      S_MUL: next = abort ? S_EIDLE : S_ACC;
      S_ACC: next = abort ? S_EIDLE : k_term ? S_IDLE : S_MUL;
      default: next = S_IDLE;
    endcase
  end
  always_comb begin
    o = OP_NOP;
    src1 = '0;
    src2 = '0;
    dest = '0;
    cnt_up = 1'b0;
    case (state)
      S_LOADC: begin o = OP_LOAD2; dest = COEF0 + {1'b0, cidx}; end
      S_SHIFT: begin o = OP_COPY; src1 = {1'b0, i}; dest = {1'b0, i} + 4'd1; end
      S_STORE: begin o = OP_LOAD1; dest = SAMPLE_REG; cnt_up = 1'b1; end
      S_ZERO: begin o = OP_SUB; dest = RESULT_REG; end
      S_MUL: begin o = OP_MUL; src1 = {1'b0, k} + 4'd1; src2 = COEF0 + {1'b0, k}; dest = TEMP_REG; end
      S_ACC: begin o = k[0] ? OP_SUB : OP_ADD; src1 = RESULT_REG; src2 = TEMP_REG; dest = RESULT_REG; end
      default: ;
    endcase
  end
  assign op = o;
  assign modwait = state inside {S_SHIFT, S_STORE, S_ZERO, S_MUL, S_ACC};
endmodule

// File: tb/tb_fir_controller.sv
// tb_fir_controller: directed bench with a micro-op schedule model and a small datapath stand-in
module tb_fir_controller;
  localparam int N = 4;
  typedef struct packed {
    logic [2:0] op;
    logic [3:0] s1, s2, d;
    logic mw, cu;
  } uop_t;
  localparam uop_t IDLE_U = '0;
  logic clk = 0, n_reset = 1, dr = 0, lc = 0, overflow = 0, go = 0;
  logic [2:0] op;
  logic [3:0] src1, src2, dest;
  logic modwait, cnt_up, err;
  logic [15:0] ext_data1 = 0, ext_data2 = 0;
  logic [15:0] rf [16];
  int total = 0, passed = 0, mw, cu;
  uop_t q[$];
  uop_t cur = IDLE_U;
  logic err_m = 0;
  int cidx_m = 0;

  fir_controller #(.NUM_TAPS(N)) dut (
    .clk(clk), .n_reset(n_reset), .dr(dr), .lc(lc), .overflow(overflow),
    .op(op), .src1(src1), .src2(src2), .dest(dest),
    .modwait(modwait), .cnt_up(cnt_up), .err(err)
  );

  always #5 clk = ~clk;

  function automatic uop_t u(int o, int s1, int s2, int d, int m, int c);
    return {3'(o), 4'(s1), 4'(s2), 4'(d), 1'(m), 1'(c)};
  endfunction

  // Expected micro-op stream: a whole sample's schedule is queued when dr is accepted
  always @(posedge clk) begin
    if (n_reset) begin
      q.delete(); cur = IDLE_U; err_m = 0; cidx_m = 0;
    end
`ifdef OVERFLOW_ABORT_EN
    else if (overflow && (cur.op == 3'd6 || (cur.mw && cur.s2 == 4'd15))) begin
      q.delete(); cur = IDLE_U; err_m = 1;
    end
`endif
    else if (q.size() > 0) cur = q.pop_front();
    else if (dr) begin
      err_m = 0;
      for (int i = N - 1; i >= 1; i--) q.push_back(u(1, i, 0, i + 1, 1, 0));
      q.push_back(u(2, 0, 0, 1, 1, 1));
      q.push_back(u(5, 0, 0, 0, 1, 0));
      for (int k = 0; k < N; k++) begin
        q.push_back(u(6, k + 1, N + 1 + k, 15, 1, 0));
        q.push_back(u(k % 2 ? 5 : 4, 0, 15, 0, 1, 0));
      end
      q.push_back(IDLE_U);
      cur = q.pop_front();
    end else if (lc) begin
      cur = u(3, 0, 0, N + 1 + cidx_m, 0, 0);
      cidx_m = (cidx_m + 1) % N;
      q.push_back(IDLE_U);
    end else cur = IDLE_U;
  end

  // Datapath stand-in executing the issued micro-ops
  always @(posedge clk) begin
    if (!go) for (int j = 0; j < 16; j++) rf[j] <= '0;
    else case (op)
      3'd1: rf[dest] <= rf[src1];
      3'd2: rf[dest] <= ext_data1;
      3'd3: rf[dest] <= ext_data2;
      3'd4: rf[dest] <= rf[src1] + rf[src2];
      3'd5: rf[dest] <= rf[src1] - rf[src2];
      3'd6: rf[dest] <= rf[src1] * rf[src2];
      default: ;
    endcase
  end

  always @(negedge clk) if (go) begin
    total++;
    if ({op, src1, src2, dest, modwait, cnt_up, err} !== {cur, err_m})
      $display("FAIL uop t=%0t: dut op=%0d s1=%0d s2=%0d d=%0d mw=%0b cu=%0b err=%0b, model op=%0d s1=%0d s2=%0d d=%0d mw=%0b cu=%0b err=%0b",
        $time, op, src1, src2, dest, modwait, cnt_up, err, cur.op, cur.s1, cur.s2, cur.d, cur.mw, cur.cu, err_m);
    else passed++;
  end

  task automatic chk(string name, int act, int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic lc_pulse(logic [15:0] v, int d);
    @(negedge clk); lc = 1; ext_data2 = v;
    @(negedge clk); lc = 0;
    chk("lc_op", op, 3);
    chk("lc_dest", dest, d);
    @(negedge clk);
  endtask

  task automatic wait_idle(output int m, output int c);
    int t = 0;
    m = 0; c = 0;
    while (modwait === 1'b1 && t < 40) begin
      m++; c += cnt_up; t++;
      @(negedge clk);
    end
    chk("seq_done", t < 40, 1);
  endtask

  task automatic run_sample(logic [15:0] v, int redrive, logic with_lc, output int m, output int c);
    int t = 0;
    @(negedge clk); dr = 1; lc = with_lc; ext_data1 = v;
    @(negedge clk); dr = 0; lc = 0;
    m = 0; c = 0;
    while (modwait === 1'b1 && t < 40) begin
      m++; c += cnt_up; t++;
      dr = (t == redrive);
      @(negedge clk);
    end
    dr = 0;
    chk("seq_done", t < 40, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    n_reset = 0; go = 1;
    chk("reset_op", op, 0);
    chk("reset_modwait", modwait, 0);
    chk("reset_err", err, 0);
    // reset landing on the second ACC (k=1, SUB)
    @(negedge clk); dr = 1; ext_data1 = 0;
    @(negedge clk); dr = 0;
    repeat (8) @(negedge clk);
    chk("pre_rst_op", op, 5);
    chk("pre_rst_src2", src2, 15);
    n_reset = 1;
    @(negedge clk); n_reset = 0;
    chk("rst_op", op, 0);
    chk("rst_modwait", modwait, 0);
    chk("rst_err", err, 0);
    run_sample(0, 0, 0, mw, cu);
    chk("fresh_busy", mw, 13);
    chk("fresh_cnt_up", cu, 1);
    lc_pulse(2, 5); lc_pulse(1, 6); lc_pulse(3, 7); lc_pulse(1, 8); lc_pulse(2, 5);
    run_sample(10, 0, 0, mw, cu);
    chk("s10_busy", mw, 13);
    chk("s10_cnt_up", cu, 1);
    chk("s10_r0", rf[0], 20);
    run_sample(20, 0, 0, mw, cu);
    chk("s20_r0", rf[0], 30);
    run_sample(30, 0, 0, mw, cu);
    chk("s30_r0", rf[0], 70);
    run_sample(40, 0, 0, mw, cu);
    chk("s40_r0", rf[0], 100);
    chk("r1", rf[1], 40); chk("r2", rf[2], 30); chk("r3", rf[3], 20); chk("r4", rf[4], 10);
    ext_data2 = 9;
    run_sample(50, 5, 1, mw, cu);
    chk("both_busy", mw, 13);
    chk("both_cnt_up", cu, 1);
    chk("both_r0", rf[0], 130);
    chk("both_r5", rf[5], 2);
    lc_pulse(16'h7FFF, 6);
    @(negedge clk); dr = 1; ext_data1 = 16'h7FFF;
    @(negedge clk); dr = 0;
    repeat (5) @(negedge clk);
    chk("ovf_mul_op", op, 6);
    overflow = 1;
    @(negedge clk); overflow = 0;
`ifdef OVERFLOW_ABORT_EN
    chk("ovf_err", err, 1);
    chk("ovf_modwait", modwait, 0);
    @(negedge clk); dr = 1; ext_data1 = 1;
    @(negedge clk); dr = 0;
    chk("ovf_clr_err", err, 0);
    chk("ovf_clr_modwait", modwait, 1);
    wait_idle(mw, cu);
`else
    chk("ovf_err", err, 0);
    chk("ovf_modwait", modwait, 1);
    wait_idle(mw, cu);
    chk("ovf_rest", mw, 7);
`endif
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fir_controller.md
Name: fir_controller

Overview:
- Moore FSM sequencer for the FIR filter; sits directly upstream of the register-file/ALU datapath.
- Converts external `dr` (sample ready) and `lc` (load coefficient) strobes into per-cycle `op`/`src1`/`src2`/`dest` micro-operations.
- Each sample shifts the tap line, stores the new sample and computes an alternating-sign multiply-accumulate into R0, the datapath's output register.

Parameters:
- NUM_TAPS, 4, number of filter taps; legal range 1..7.

Ports:
- clk  input  1  system clock
- n_reset  input  1  reset: synchronous, active-high (asserted = 1)
- dr  input  1  new sample valid on `ext_data1` this cycle
- lc  input  1  new coefficient valid on `ext_data2` this cycle
- overflow  input  1  datapath ALU overflow for the current op
- op  output  3  datapath opcode
- src1  output  4  read select 1
- src2  output  4  read select 2
- dest  output  4  write select
- modwait  output  1  busy (sample processing in progress)
- cnt_up  output  1  one-cycle pulse per accepted sample
- err  output  1  overflow error flag (sticky)

Behaviour:
- Register map:
  - R0: result.
  - R1..R_N: samples, R1 newest.
  - R(N+1)..R(2N): coefficients F0..F(N-1).
  - R15: product temp.
- Opcodes:
  - NOP=0, COPY=1 (dest<=src1), LOAD1=2 (ext_data1), LOAD2=3 (ext_data2), ADD=4, SUB=5, MUL=6.
  - Outputs are purely a function of state and counters.
  - src/dest not used by the current op are driven 0.
- Reset, synchronous, at any time including mid-sequence:
  - state=IDLE; tap and coefficient counters = 0; err=0.
  - Outputs: op=NOP, modwait=0, cnt_up=0.
- States:
  - IDLE (op=NOP):
    - dr -> SHIFT, or STORE when N=1.
    - else lc -> LOADC.
    - dr has priority over lc when both are asserted.
  - LOADC (1 cycle): op=LOAD2, dest=N+1+cidx; cidx increments and wraps N-1 -> 0; -> IDLE.
  - SHIFT:
    - i runs N-1 down to 1, one cycle each: op=COPY, src1=i, dest=i+1.
    - After i=1 -> STORE.
  - STORE: op=LOAD1, dest=1, cnt_up=1; -> ZERO.
  - ZERO: op=SUB, src1=0, src2=0, dest=0; -> MUL with k=0.
  - MUL: op=MUL, src1=k+1, src2=N+1+k, dest=15; -> ACC.
  - ACC:
    - op = ADD if k is even, SUB if k is odd; src1=0, src2=15, dest=0.
    - k==N-1 -> IDLE; else k++ and -> MUL.
  - EIDLE: op=NOP, err=1; dr -> SHIFT with err cleared, lc -> LOADC with err held, else stay.
- modwait=1 in SHIFT, STORE, ZERO, MUL and ACC; 0 in IDLE, LOADC and EIDLE.
- Latency: busy for 3N+1 cycles after the `dr` edge (13 for N=4); R0 is valid and modwait=0 on the following cycle.
- `dr`/`lc` asserted while busy or in LOADC are ignored, not queued.

Optional Feature:
- OVERFLOW_ABORT_EN defined:
  - `overflow`=1 during MUL or ACC -> EIDLE next cycle.
  - R0 keeps whatever the datapath wrote.
- Not defined:
  - `overflow` ignored; sequence completes normally.
  - err tied 0; EIDLE unreachable.

Decomposition:
- Package fir_pkg:
  - op_t enum with the opcodes above.
  - state_t enum.
  - Register-index constants (RESULT_REG=0, TEMP_REG=15).
- Sub-module fir_ctrl_counter: down/up tap counter with load and terminal flag, reused for SHIFT (`i`) and MUL/ACC (`k`).

Test Plan:
- Reset mid-ACC -> next cycle IDLE, op=0, modwait=0, err=0; a fresh dr sequence runs normally.
- Four lc pulses with ext_data2=2,1,3,1 -> LOAD2 to dest 5,6,7,8 in order; a fifth lc writes dest 5 (cidx wrap).
- Then dr with ext_data1=10 -> cnt_up pulses once; modwait high for exactly 13 cycles; outreg_data=20.
- Further dr with samples 20, 30, 40 -> final R1..R4 = 40,30,20,10; outreg_data = 80-30+60-10 = 100.
- dr and lc asserted together in IDLE -> SHIFT taken, no coefficient written; dr re-asserted while modwait=1 -> ignored, cnt_up still one pulse.
- OVERFLOW_ABORT_EN: coefficient 0x7FFF, sample 0x7FFF, overflow=1 in MUL -> EIDLE, err=1, modwait=0; next dr -> err=0, modwait=1. Without macro -> err stays 0 and the sequence completes.
